usb_cmd_parser: RTL and testbench

- Decodes host command frames that the FX2 slave-FIFO read path delivers as a 16-bit word stream.
- Applies each valid frame to the board configuration: demodulation mode/gain/channel, excitation frequency divider, and reset/sleep control of the ECT and ERT boards.
- Sits between the usb_clk-domain FX2 controller and the measurement boards.
- Provides frame framing, validation, timeout recovery, timed reset pulses and an error counter.

---
 rtl/usb_cmd_pkg.sv | 68 ++++++
 rtl/rst_pulse_gen.sv | 35 +++
 rtl/usb_cmd_parser.sv | 192 +++++++++++++++++++
 tb/tb_usb_cmd_parser.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_cmd_pkg.sv
// rtl/usb_cmd_pkg.sv - shared framing constants, opcodes and state encodings for the host command path
package usb_cmd_pkg;

  localparam logic [7:0] CMD_HEAD = 8'h53;
  localparam logic [7:0] CMD_TAIL = 8'hCD;
  localparam int         CMD_LEN  = 8;

  localparam logic [7:0] CMD_SETUP_ALL = 8'hA0;
  localparam logic [7:0] CMD_SETUP_ECT = 8'hA1;
  localparam logic [7:0] CMD_SETUP_ERT = 8'hA2;
  localparam logic [7:0] CMD_RST_ALL   = 8'h35;
  localparam logic [7:0] CMD_RST_ECT   = 8'h36;
  localparam logic [7:0] CMD_RST_ERT   = 8'h37;
  localparam logic [7:0] CMD_SLP_ALL   = 8'h11;
  localparam logic [7:0] CMD_SLP_ECT   = 8'h12;
  localparam logic [7:0] CMD_SLP_ERT   = 8'h13;
  localparam logic [7:0] CMD_FREQ_ALL  = 8'h70;
  localparam logic [7:0] CMD_FREQ_ECT  = 8'h71;
  localparam logic [7:0] CMD_FREQ_ERT  = 8'h72;

  localparam int RS_ECT_RST = 3;
  localparam int RS_ERT_RST = 2;
  localparam int RS_ECT_SLP = 1;
  localparam int RS_ERT_SLP = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BODY = 2'd1,
    S_EXEC = 2'd2
  } parser_state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_SETUP = 3'd1,
    OP_RESET = 3'd2,
    OP_SLEEP = 3'd3,
    OP_FREQ  = 3'd4
  } op_kind_t;

  typedef struct packed {
    op_kind_t kind;
    logic     ect;
    logic     ert;
  } op_dec_t;

  // Opcode -> operation class plus the board(s) it addresses
  function automatic op_dec_t decode_cmd(input logic [7:0] cmd);
    op_dec_t d;
    d = '{kind: OP_NONE, ect: 1'b0, ert: 1'b0};
    case (cmd)
      CMD_SETUP_ALL: d = '{kind: OP_SETUP, ect: 1'b1, ert: 1'b1};
      CMD_SETUP_ECT: d = '{kind: OP_SETUP, ect: 1'b1, ert: 1'b0};
      CMD_SETUP_ERT: d = '{kind: OP_SETUP, ect: 1'b0, ert: 1'b1};
      CMD_RST_ALL:   d = '{kind: OP_RESET, ect: 1'b1, ert: 1'b1};
      CMD_RST_ECT:   d = '{kind: OP_RESET, ect: 1'b1, ert: 1'b0};
      CMD_RST_ERT:   d = '{kind: OP_RESET, ect: 1'b0, ert: 1'b1};
      CMD_SLP_ALL:   d = '{kind: OP_SLEEP, ect: 1'b1, ert: 1'b1};
      CMD_SLP_ECT:   d = '{kind: OP_SLEEP, ect: 1'b1, ert: 1'b0};
      CMD_SLP_ERT:   d = '{kind: OP_SLEEP, ect: 1'b0, ert: 1'b1};
      CMD_FREQ_ALL:  d = '{kind: OP_FREQ,  ect: 1'b1, ert: 1'b1};
      CMD_FREQ_ECT:  d = '{kind: OP_FREQ,  ect: 1'b1, ert: 1'b0};
      CMD_FREQ_ERT:  d = '{kind: OP_FREQ,  ect: 1'b0, ert: 1'b1};
      default:       d = '{kind: OP_NONE,  ect: 1'b0, ert: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rst_pulse_gen.sv
// rtl/rst_pulse_gen.sv - fixed-width active-low board reset pulses with reload and target merge
module rst_pulse_gen #(
  parameter int RST_PULSE = 48
) (
  input  logic       usb_clk,
  input  logic       sys_rst,
  input  logic       load,
  input  logic [1:0] tgt,
  output logic [1:0] pulse_n
);

  localparam int CW = $clog2(RST_PULSE + 1);

  logic [CW-1:0] cnt;
  logic [1:0]    act;

  // A reload during a live pulse widens the target set; all bits release together
  always_ff @(posedge usb_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt <= '0;
      act <= 2'b00;
    end else if (load) begin
      cnt <= CW'(RST_PULSE);
      act <= (cnt != '0) ? (act | tgt) : tgt;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        act <= 2'b00;
      end
    end
  end

  assign pulse_n = ~act;

endmodule

// File: rtl/usb_cmd_parser.sv
// rtl/usb_cmd_parser.sv - frames FX2 command words, validates them and applies board configuration
module usb_cmd_parser
  import usb_cmd_pkg::*;
#(
  parameter int FRM_LEN   = CMD_LEN,
  parameter int TIMEOUT   = 1024,
  parameter int RST_PULSE = 48
) (
  input  logic        usb_clk,
  input  logic        sys_rst,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_word,
  output logic        cmd_ready,
  output logic [3:0]  demod_mode,
  output logic [3:0]  pga_gain,
  output logic [7:0]  demod_chn,
  output logic [15:0] ect_freq,
  output logic [15:0] ert_freq,
  output logic [3:0]  rst_sleep,
  output logic        cfg_update,
  output logic [7:0]  frm_err_cnt
);

  localparam int IW = $clog2(FRM_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);

  parser_state_t state, state_nxt;

  logic [IW-1:0] idx;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    cmd_q;
  logic [15:0]   w1_q;
  logic [15:0]   w2_q;
  logic          tail_ok_q;
  logic [1:0]    slp;
  logic [1:0]    pulse_n;

  logic    accept;
  logic    hdr_hit;
  logic    last_word;
  logic    tmo_hit;
  logic    err_inc;
  logic    exec_ok;
  logic    pulse_load;
  op_dec_t dec;

  assign cmd_ready = (state != S_EXEC);
  assign accept    = cmd_valid && cmd_ready;
  assign hdr_hit   = (cmd_word[7:0] == CMD_HEAD);
  assign last_word = (idx == IW'(FRM_LEN - 1));
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT));
  assign dec       = decode_cmd(cmd_q);

  always_ff @(posedge usb_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Error sources live in disjoint states, so at most one increment per cycle
  always_comb begin
    state_nxt = state;
    err_inc   = 1'b0;
    exec_ok   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (hdr_hit) begin
            state_nxt = S_BODY;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      S_BODY: begin
        if (accept) begin
          if (last_word) begin
            state_nxt = S_EXEC;
          end
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
          err_inc   = 1'b1;
        end
      end
      S_EXEC: begin
        state_nxt = S_IDLE;
        if (tail_ok_q && (dec.kind != OP_NONE)) begin
          exec_ok = 1'b1;
        end else begin
          err_inc = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Only w1, w2 and the tail byte carry information; reserved words are dropped
  always_ff @(posedge usb_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      idx       <= '0;
      tmo_cnt   <= '0;
      cmd_q     <= 8'h00;
      w1_q      <= 16'h0000;
      w2_q      <= 16'h0000;
      tail_ok_q <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        tmo_cnt <= '0;
        if (accept && hdr_hit) begin
          cmd_q <= cmd_word[15:8];
          idx   <= IW'(1);
        end
      end else if (state == S_BODY) begin
        if (accept) begin
          tmo_cnt <= '0;
          idx     <= idx + 1'b1;
          if (idx == IW'(1)) begin
            w1_q <= cmd_word;
          end
          if (idx == IW'(2)) begin
            w2_q <= cmd_word;
          end
          if (last_word) begin
            tail_ok_q <= (cmd_word[7:0] == CMD_TAIL);
          end
        end else if (!tmo_hit) begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge usb_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      demod_mode  <= 4'h0;
      pga_gain    <= 4'h0;
      demod_chn   <= 8'h00;
      ect_freq    <= 16'h0000;
      ert_freq    <= 16'h0000;
      slp         <= 2'b11;
      cfg_update  <= 1'b0;
      frm_err_cnt <= 8'h00;
    end else begin
      cfg_update <= exec_ok;
      if (err_inc && (frm_err_cnt != 8'hFF)) begin
        frm_err_cnt <= frm_err_cnt + 8'd1;
      end
      if (exec_ok) begin
        case (dec.kind)
          OP_SETUP: begin
            demod_mode <= w1_q[3:0];
            pga_gain   <= w1_q[7:4];
            demod_chn  <= w1_q[15:8];
          end
          OP_FREQ: begin
            if (dec.ect) ect_freq <= w2_q;
            if (dec.ert) ert_freq <= w2_q;
          end
          default: ;
        endcase
        // Setup and reset both wake their target; sleep puts it down
        if ((dec.kind == OP_SETUP) || (dec.kind == OP_RESET)) begin
          if (dec.ect) slp[1] <= 1'b1;
          if (dec.ert) slp[0] <= 1'b1;
        end else if (dec.kind == OP_SLEEP) begin
          if (dec.ect) slp[1] <= 1'b0;
          if (dec.ert) slp[0] <= 1'b0;
        end
      end
    end
  end

  assign pulse_load = exec_ok && (dec.kind == OP_RESET);

  rst_pulse_gen #(
    .RST_PULSE (RST_PULSE)
  ) u_rst_pulse_gen (
    .usb_clk (usb_clk),
    .sys_rst (sys_rst),
    .load    (pulse_load),
    .tgt     ({dec.ect, dec.ert}),
    .pulse_n (pulse_n)
  );

  assign rst_sleep[RS_ECT_RST] = pulse_n[1];
  assign rst_sleep[RS_ERT_RST] = pulse_n[0];
  assign rst_sleep[RS_ECT_SLP] = slp[1];
  assign rst_sleep[RS_ERT_SLP] = slp[0];

endmodule

// File: tb/tb_usb_cmd_parser.sv
// tb/tb_usb_cmd_parser.sv - randomized self-checking bench for usb_cmd_parser with a frame-level model
module tb_usb_cmd_parser;

  logic        usb_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_word = 16'h0000;
  logic        cmd_ready;
  logic [3:0]  demod_mode;
  logic [3:0]  pga_gain;
  logic [7:0]  demod_chn;
  logic [15:0] ect_freq;
  logic [15:0] ert_freq;
  logic [3:0]  rst_sleep;
  logic        cfg_update;
  logic [7:0]  frm_err_cnt;

  always #10 usb_clk = ~usb_clk;

  usb_cmd_parser dut (
    .usb_clk     (usb_clk),
    .sys_rst     (sys_rst),
    .cmd_valid   (cmd_valid),
    .cmd_word    (cmd_word),
    .cmd_ready   (cmd_ready),
    .demod_mode  (demod_mode),
    .pga_gain    (pga_gain),
    .demod_chn   (demod_chn),
    .ect_freq    (ect_freq),
    .ert_freq    (ert_freq),
    .rst_sleep   (rst_sleep),
    .cfg_update  (cfg_update),
    .frm_err_cnt (frm_err_cnt)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: board configuration as the host sees it
  logic [3:0]  m_mode;
  logic [3:0]  m_gain;
  logic [7:0]  m_chn;
  logic [15:0] m_ef;
  logic [15:0] m_rf;
  logic [1:0]  m_rst_low;
  logic [1:0]  m_slp;
  logic [7:0]  m_err;

  logic [59:0] dut_vec;
  assign dut_vec = {demod_mode, pga_gain, demod_chn, ect_freq, ert_freq, rst_sleep, frm_err_cnt};

  function automatic logic [59:0] exp_vec();
    return {m_mode, m_gain, m_chn, m_ef, m_rf, ~m_rst_low, m_slp, m_err};
  endfunction

  task automatic model_reset();
    m_mode = 4'h0; m_gain = 4'h0; m_chn = 8'h00;
    m_ef = 16'h0000; m_rf = 16'h0000;
    m_rst_low = 2'b00; m_slp = 2'b11; m_err = 8'h00;
  endtask

  task automatic model_err();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  function automatic logic [7:0] base_of(input int k);
    case (k)
      0: return 8'hA0;
      1: return 8'h35;
      2: return 8'h11;
      default: return 8'h70;
    endcase
  endfunction

  // Each opcode family is base+0 (both boards), base+1 (ECT), base+2 (ERT)
  task automatic model_frame(input logic [7:0] cmd, input logic [15:0] w1, input logic [15:0] w2,
                             input logic [7:0] tail, output bit applied);
    int kind;
    logic [1:0] tg;
    kind = -1;
    tg = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (cmd >= base_of(k) && cmd <= base_of(k) + 8'd2) begin
        kind = k;
        tg = (cmd == base_of(k)) ? 2'b11 : ((cmd == base_of(k) + 8'd1) ? 2'b10 : 2'b01);
      end
    end
    applied = (tail == 8'hCD) && (kind >= 0);
    if (!applied) begin
      model_err();
    end else begin
      case (kind)
        0: begin m_mode = w1[3:0]; m_gain = w1[7:4]; m_chn = w1[15:8]; m_slp = m_slp | tg; end
        1: begin m_rst_low = m_rst_low | tg; m_slp = m_slp | tg; end
        2: m_slp = m_slp & ~tg;
        default: begin
          if (tg[1]) m_ef = w2;
          if (tg[0]) m_rf = w2;
        end
      endcase
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic send_word(input logic [15:0] w);
    int guard;
    cmd_valid = 1'b1;
    cmd_word = w;
    guard = 0;
    while (!cmd_ready && guard < 10) begin
      @(negedge usb_clk);
      guard++;
    end
    if (guard >= 10) begin
      checks++;
      $display("FAIL send_word_ready_stuck cmd_ready=%b required 1", cmd_ready);
    end
    @(negedge usb_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] w1, input logic [15:0] w2,
                            input logic [7:0] tail, input bit gaps);
    logic [15:0] words [8];
    words[0] = {cmd, 8'h53};
    words[1] = w1;
    words[2] = w2;
    for (int i = 3; i < 7; i++) words[i] = 16'($urandom);
    words[7] = {8'($urandom), tail};
    for (int i = 0; i < 8; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge usb_clk);
      send_word(words[i]);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    model_reset();
    repeat (3) @(negedge usb_clk);
    checks++; if (dut_vec !== exp_vec()) $display("FAIL reset_vec got %h required %h", dut_vec, exp_vec()); else passed++;
    checks++; if (cmd_ready !== 1'b1 || cfg_update !== 1'b0) $display("FAIL reset_ctl got ready=%b upd=%b required 1/0", cmd_ready, cfg_update); else passed++;
    sys_rst = 1'b1;
    @(negedge usb_clk);
    checks++; if (dut_vec !== exp_vec()) $display("FAIL reset_release_vec got %h required %h", dut_vec, exp_vec()); else passed++;
  endtask

  task automatic test_setup();
    bit ap;
    model_frame(8'hA0, 16'h0A37, 16'h0000, 8'hCD, ap);
    send_frame(8'hA0, 16'h0A37, 16'h0000, 8'hCD, 1'b0);
    checks++; if (cfg_update !== 1'b0 || cmd_ready !== 1'b0) $display("FAIL setup_exec_cycle got upd=%b ready=%b required 0/0", cfg_update, cmd_ready); else passed++;
    @(negedge usb_clk);
    checks++; if (cfg_update !== 1'b1) $display("FAIL setup_upd_t2 got %b required 1", cfg_update); else passed++;
    checks++; if ({demod_mode, pga_gain, demod_chn} !== {4'h7, 4'h3, 8'h0A}) $display("FAIL setup_fields got %h required 730a", {demod_mode, pga_gain, demod_chn}); else passed++;
    checks++; if (dut_vec !== exp_vec()) $display("FAIL setup_vec got %h required %h", dut_vec, exp_vec()); else passed++;
    @(negedge usb_clk);
    checks++; if (cfg_update !== 1'b0) $display("FAIL setup_upd_once got %b required 0", cfg_update); else passed++;
  endtask

  task automatic test_reset_pulse();
    bit ap;
    int n;
    bit glitch;
    model_frame(8'h36, 16'h0000, 16'h0000, 8'hCD, ap);
    send_frame(8'h36, 16'h0000, 16'h0000, 8'hCD, 1'b0);
    @(negedge usb_clk);
    checks++; if (dut_vec !== exp_vec()) $display("FAIL pulse_start_vec got %h required %h", dut_vec, exp_vec()); else passed++;
    n = 0; glitch = 0;
    while (rst_sleep[3] === 1'b0 && n < 200) begin
      if (rst_sleep[2:0] !== 3'b111) glitch = 1;
      n++;
      @(negedge usb_clk);
    end
    checks++; if (n != 48) $display("FAIL pulse_width got %0d required 48", n); else passed++;
    checks++; if (glitch) $display("FAIL pulse_other_bits got disturbed=1 required 0"); else passed++;
    m_rst_low = 2'b00;
    checks++; if (dut_vec !== exp_vec()) $display("FAIL pulse_end_vec got %h required %h", dut_vec, exp_vec()); else passed++;
    // Second reset command lands while the first pulse is still live
    model_frame(8'h36, 16'h0000, 16'h0000, 8'hCD, ap);
    send_frame(8'h36, 16'h0000, 16'h0000, 8'hCD, 1'b0);
    @(negedge usb_clk);
    repeat (29) @(negedge usb_clk);
    model_frame(8'h37, 16'h0000, 16'h0000, 8'hCD, ap);
    send_frame(8'h37, 16'h0000, 16'h0000, 8'hCD, 1'b0);
    @(negedge usb_clk);
    checks++; if (dut_vec !== exp_vec()) $display("FAIL merge_start_vec got %h required %h", dut_vec, exp_vec()); else passed++;
    n = 0;
    while (rst_sleep[3:2] === 2'b00 && n < 200) begin
      n++;
      @(negedge usb_clk);
    end
    checks++; if (n != 48) $display("FAIL merge_width got %0d required 48", n); else passed++;
    m_rst_low = 2'b00;
    checks++; if (dut_vec !== exp_vec()) $display("FAIL merge_end_vec got %h required %h", dut_vec, exp_vec()); else passed++;
  endtask

  task automatic test_sleep();
    bit ap;
    logic [15:0] w1;
    model_frame(8'h12, 16'h0000, 16'h0000, 8'hCD, ap);
    send_frame(8'h12, 16'h0000, 16'h0000, 8'hCD, 1'b1);
    @(negedge usb_clk);
    checks++; if (rst_sleep !== 4'b1101) $display("FAIL sleep_ect got %b required 1101", rst_sleep); else passed++;
    checks++; if (dut_vec !== exp_vec()) $display("FAIL sleep_vec got %h required %h", dut_vec, exp_vec()); else passed++;
    w1 = 16'($urandom);
    model_frame(8'hA1, w1, 16'h0000, 8'hCD, ap);
    send_frame(8'hA1, w1, 16'h0000, 8'hCD, 1'b1);
    @(negedge usb_clk);
    checks++; if (rst_sleep !== 4'b1111) $display("FAIL wake_ect got %b required 1111", rst_sleep); else passed++;
    checks++; if (dut_vec !== exp_vec()) $display("FAIL wake_vec got %h required %h", dut_vec, exp_vec()); else passed++;
  endtask

  task automatic test_bad_tail();
    bit ap;
    model_frame(8'h70, 16'h0000, 16'hBEEF, 8'hCC, ap);
    send_frame(8'h70, 16'h0000, 16'hBEEF, 8'hCC, 1'b0);
    @(negedge usb_clk);
    checks++; if (cfg_update !== 1'b0) $display("FAIL badtail_upd got %b required 0", cfg_update); else passed++;
    checks++; if (frm_err_cnt !== 8'd1) $display("FAIL badtail_err got %0d required 1", frm_err_cnt); else passed++;
    checks++; if (dut_vec !== exp_vec()) $display("FAIL badtail_vec got %h required %h", dut_vec, exp_vec()); else passed++;
    model_frame(8'h71, 16'h0000, 16'h1234, 8'hCD, ap);
    send_frame(8'h71, 16'h0000, 16'h1234, 8'hCD, 1'b0);
    @(negedge usb_clk);
    checks++; if (ect_freq !== 16'h1234 || ert_freq !== 16'h0000) $display("FAIL freq_ect got %h/%h required 1234/0000", ect_freq, ert_freq); else passed++;
    checks++; if (dut_vec !== exp_vec()) $display("FAIL freq_vec got %h required %h", dut_vec, exp_vec()); else passed++;
  endtask

  task automatic test_timeout();
    bit ap;
    logic [15:0] w2;
    send_word({8'h72, 8'h53});
    send_word(16'h1111);
    send_word(16'h5555);
    send_word(16'h0000);
    repeat (1100) @(negedge usb_clk);
    model_err();
    checks++; if (dut_vec !== exp_vec()) $display("FAIL timeout_vec got %h required %h", dut_vec, exp_vec()); else passed++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL timeout_ready got %b required 1", cmd_ready); else passed++;
    w2 = 16'($urandom);
    model_frame(8'h72, 16'h0000, w2, 8'hCD, ap);
    send_frame(8'h72, 16'h0000, w2, 8'hCD, 1'b0);
    @(negedge usb_clk);
    checks++; if (cfg_update !== 1'b1) $display("FAIL post_timeout_upd got %b required 1", cfg_update); else passed++;
    checks++; if (dut_vec !== exp_vec()) $display("FAIL post_timeout_vec got %h required %h", dut_vec, exp_vec()); else passed++;
    // A long but sub-timeout stall must not break the frame
    w2 = 16'($urandom);
    model_frame(8'h70, 16'h0000, w2, 8'hCD, ap);
    send_word({8'h70, 8'h53});
    send_word(16'h0000);
    send_word(w2);
    send_word(16'h0000);
    repeat (1000) @(negedge usb_clk);
    send_word(16'h0000);
    send_word(16'h0000);
    send_word(16'h0000);
    send_word(16'h00CD);
    @(negedge usb_clk);
    checks++; if (cfg_update !== 1'b1) $display("FAIL stall_upd got %b required 1", cfg_update); else passed++;
    checks++; if (dut_vec !== exp_vec()) $display("FAIL stall_vec got %h required %h", dut_vec, exp_vec()); else passed++;
  endtask

  task automatic test_random();
    bit ap;
    logic [7:0]  cmd;
    logic [7:0]  tail;
    logic [15:0] w1, w2, sw;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 4) == 0) begin
        sw = 16'($urandom);
        if (sw[7:0] == 8'h53) sw[7:0] = 8'h00;
        send_word(sw);
        model_err();
      end
      if ($urandom_range(0, 9) < 7) cmd = base_of(int'($urandom_range(0, 3))) + 8'($urandom_range(0, 2));
      else cmd = 8'($urandom);
      tail = ($urandom_range(0, 9) == 0) ? 8'hCC : 8'hCD;
      w1 = 16'($urandom);
      w2 = 16'($urandom);
      model_frame(cmd, w1, w2, tail, ap);
      send_frame(cmd, w1, w2, tail, f[0]);
      @(negedge usb_clk);
      checks++; if (cfg_update !== ap) $display("FAIL rand_upd frame %0d cmd %h got %b required %b", f, cmd, cfg_update, ap); else passed++;
      checks++; if (dut_vec !== exp_vec()) $display("FAIL rand_vec frame %0d cmd %h got %h required %h", f, cmd, dut_vec, exp_vec()); else passed++;
      if (m_rst_low != 2'b00) begin
        repeat (60) @(negedge usb_clk);
        m_rst_low = 2'b00;
        checks++; if (dut_vec !== exp_vec()) $display("FAIL rand_pulse_end frame %0d got %h required %h", f, dut_vec, exp_vec()); else passed++;
      end
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      send_word({8'($urandom), 8'h00});
      model_err();
    end
    checks++; if (frm_err_cnt !== 8'hFF) $display("FAIL err_saturate got %h required ff", frm_err_cnt); else passed++;
    checks++; if (dut_vec !== exp_vec()) $display("FAIL saturate_vec got %h required %h", dut_vec, exp_vec()); else passed++;
  endtask

  task automatic test_async_reset();
    bit ap;
    logic [15:0] w1;
    model_frame(8'h35, 16'h0000, 16'h0000, 8'hCD, ap);
    send_frame(8'h35, 16'h0000, 16'h0000, 8'hCD, 1'b0);
    @(negedge usb_clk);
    checks++; if (dut_vec !== exp_vec()) $display("FAIL rstall_vec got %h required %h", dut_vec, exp_vec()); else passed++;
    repeat (5) @(negedge usb_clk);
    send_word({8'hA0, 8'h53});
    send_word(16'h1234);
    #3;
    sys_rst = 1'b0;
    #1;
    model_reset();
    checks++; if (dut_vec !== exp_vec()) $display("FAIL async_rst_vec got %h required %h", dut_vec, exp_vec()); else passed++;
    checks++; if (cmd_ready !== 1'b1 || cfg_update !== 1'b0) $display("FAIL async_rst_ctl got ready=%b upd=%b required 1/0", cmd_ready, cfg_update); else passed++;
    @(negedge usb_clk);
    sys_rst = 1'b1;
    @(negedge usb_clk);
    w1 = 16'($urandom);
    model_frame(8'hA2, w1, 16'h0000, 8'hCD, ap);
    send_frame(8'hA2, w1, 16'h0000, 8'hCD, 1'b0);
    @(negedge usb_clk);
    checks++; if (cfg_update !== 1'b1) $display("FAIL after_rst_upd got %b required 1", cfg_update); else passed++;
    checks++; if (dut_vec !== exp_vec()) $display("FAIL after_rst_vec got %h required %h", dut_vec, exp_vec()); else passed++;
  endtask

  initial begin
    test_reset();
    test_setup();
    test_reset_pulse();
    test_sleep();
    test_bad_tail();
    test_timeout();
    test_random();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
